// File: rtl/lock_pkg.sv
// Definitions shared by the key sequence transmitter and the sequence lock receiver,
// so the unlock code is defined in one place.
package lock_pkg;

  // Transmitter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Unlock code length and value
  localparam int unsigned LOCK_CODE_W = 5;
  localparam logic [LOCK_CODE_W-1:0] LOCK_CODE = 5'b11010;

endpackage

// File: rtl/key_sequence_tx.sv
// Serial key transmitter: latches a code on start, shifts it out MSB-first,
// then holds key low for a guard gap so the lock receiver returns to idle.
import lock_pkg::*;

module key_sequence_tx #(
  parameter int unsigned          CODE_W       = LOCK_CODE_W,
  parameter int unsigned          GAP_CYCLES   = 2,
  parameter logic [CODE_W-1:0]    DEFAULT_CODE = LOCK_CODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              use_default,
  input  logic [CODE_W-1:0] code_in,
  input  logic              abort,
  output logic              key,
  output logic              key_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BIT_W = $clog2(CODE_W);
  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  state_t              r_state;
  logic [CODE_W-1:0]   r_shreg;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic                r_key;
  logic                r_key_valid;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nx;
  logic [CODE_W-1:0]   w_shreg_nx;
  logic [BIT_W-1:0]    w_bit_cnt_nx;
  logic [GAP_W-1:0]    w_gap_cnt_nx;
  logic                w_key_nx;
  logic                w_key_valid_nx;
  logic                w_busy_nx;
  logic                w_done_nx;
  logic                w_load;
  logic                w_finish;
  logic                w_cancel;
  logic [CODE_W-1:0]   w_code_sel;

  assign w_code_sel = use_default ? DEFAULT_CODE : code_in;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_key       <= 1'b0;
      r_key_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_shreg     <= w_shreg_nx;
      r_bit_cnt   <= w_bit_cnt_nx;
      r_gap_cnt   <= w_gap_cnt_nx;
      r_key       <= w_key_nx;
      r_key_valid <= w_key_valid_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nx     = r_state;
    w_shreg_nx     = r_shreg;
    w_bit_cnt_nx   = r_bit_cnt;
    w_gap_cnt_nx   = r_gap_cnt;
    w_key_nx       = 1'b0;
    w_key_valid_nx = 1'b0;
    w_busy_nx      = r_busy;
    w_done_nx      = 1'b0;
    w_load         = 1'b0;
    w_finish       = 1'b0;
    w_cancel       = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_busy_nx = 1'b0;
        w_load    = start && !abort;
      end
      SEND: begin
        if (abort) begin
          w_cancel = 1'b1;
        end else if (r_bit_cnt != '0) begin
          w_shreg_nx     = r_shreg << 1;
          w_key_nx       = r_shreg[CODE_W-2];
          w_key_valid_nx = 1'b1;
          w_bit_cnt_nx   = r_bit_cnt - BIT_W'(1);
        end else if (GAP_CYCLES == 0) begin
          w_finish = 1'b1;
        end else begin
          w_state_nx   = GAP;
          w_gap_cnt_nx = GAP_W'(GAP_CYCLES);
        end
      end
      GAP: begin
        if (abort) begin
          w_cancel = 1'b1;
        end else if (r_gap_cnt <= GAP_W'(1)) begin
          w_finish = 1'b1;
        end else begin
          w_gap_cnt_nx = r_gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        w_cancel = 1'b1;
      end
    endcase

    if (w_cancel) begin
      w_state_nx   = IDLE;
      w_busy_nx    = 1'b0;
      w_bit_cnt_nx = '0;
      w_gap_cnt_nx = '0;
    end

    // Completion edge doubles as the first idle sampling point of start, so a
    // held start restarts with no bubble beyond the gap (done still pulses).
    if (w_finish) begin
      w_done_nx    = 1'b1;
      w_state_nx   = IDLE;
      w_busy_nx    = 1'b0;
      w_gap_cnt_nx = '0;
      w_load       = start;
    end

    if (w_load) begin
      w_shreg_nx     = w_code_sel;
      w_bit_cnt_nx   = BIT_W'(CODE_W - 1);
      w_key_nx       = w_code_sel[CODE_W-1];
      w_key_valid_nx = 1'b1;
      w_busy_nx      = 1'b1;
      w_state_nx     = SEND;
    end
  end

  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_key_sequence_tx.sv
// Directed bench for key_sequence_tx with a 2-cycle gap and a zero-gap instance.
module tb_key_sequence_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic       use_default;
  logic       abort;
  logic [4:0] code_in;

  logic key, key_valid, busy, done;
  logic key0, key_valid0, busy0, done0;

  int n_checks;
  int n_errors;
  int n_done;

  key_sequence_tx #(
    .CODE_W       (5),
    .GAP_CYCLES   (2),
    .DEFAULT_CODE (5'b11010)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .use_default (use_default),
    .code_in     (code_in),
    .abort       (abort),
    .key         (key),
    .key_valid   (key_valid),
    .busy        (busy),
    .done        (done)
  );

  key_sequence_tx #(
    .CODE_W       (5),
    .GAP_CYCLES   (0),
    .DEFAULT_CODE (5'b11010)
  ) dut0 (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .use_default (use_default),
    .code_in     (code_in),
    .abort       (abort),
    .key         (key0),
    .key_valid   (key_valid0),
    .busy        (busy0),
    .done        (done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks key/key_valid/busy/done of the gap-2 instance
  task automatic chk_out(input string tag, input logic k, input logic kv, input logic b, input logic d);
    chk({tag, ".key"}, {31'd0, key}, {31'd0, k});
    chk({tag, ".key_valid"}, {31'd0, key_valid}, {31'd0, kv});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
  endtask

  initial begin
    logic [4:0] code;
    logic [6:0] pat7;
    logic [4:0] pat5;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    start = 1'b0;
    use_default = 1'b0;
    abort = 1'b0;
    code_in = 5'b00000;

    // Reset state
    tick();
    tick();
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.busy0", {31'd0, busy0}, 32'd0);
    rst = 1'b1;
    tick();

    // Default code, single transfer: bits on edges N..N+4, gap N+5..N+6, done at N+7
    code = 5'b11010;
    start = 1'b1;
    use_default = 1'b1;
    tick();
    start = 1'b0;
    use_default = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("dflt.bit%0d", i), code[4-i], 1'b1, 1'b1, 1'b0);
      chk($sformatf("dflt0.key%0d", i), {31'd0, key0}, {31'd0, code[4-i]});
      tick();
    end
    chk_out("dflt.gap0", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("dflt0.done", {31'd0, done0}, 32'd1);
    chk("dflt0.busy", {31'd0, busy0}, 32'd0);
    tick();
    chk_out("dflt.gap1", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("dflt0.done_clr", {31'd0, done0}, 32'd0);
    tick();
    chk_out("dflt.done", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("dflt.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // code_in path; code_in/use_default and a stray start changed mid-transfer
    code = 5'b10110;
    code_in = code;
    use_default = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    code_in = 5'b01001;
    use_default = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("cin.bit%0d", i), code[4-i], 1'b1, 1'b1, 1'b0);
      start = (i == 2);
      tick();
    end
    start = 1'b0;
    chk_out("cin.gap0", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    chk_out("cin.done", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("cin.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // start held high: back-to-back, period 7 (gap 2) and 5 (gap 0)
    use_default = 1'b1;
    start = 1'b1;
    tick();
    pat7 = 7'b1101000;
    pat5 = 5'b11010;
    n_done = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk($sformatf("b2b.key%0d", i), {31'd0, key}, {31'd0, pat7[6 - (i % 7)]});
      chk($sformatf("b2b.done%0d", i), {31'd0, done}, {31'd0, ((i % 7) == 0)});
      chk($sformatf("b2b.key0_%0d", i), {31'd0, key0}, {31'd0, pat5[4 - (i % 5)]});
      chk($sformatf("b2b.done0_%0d", i), {31'd0, done0}, {31'd0, ((i % 5) == 0)});
      if (done) n_done++;
    end
    chk("b2b.ndone", n_done, 32'd2);
    chk("b2b.busy_at_restart", {31'd0, busy}, 32'd1);
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk_out("b2b.drained", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b.drained0", {31'd0, busy0}, 32'd0);

    // abort together with start in IDLE: dropped
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk_out("abort_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // abort on the 3rd code bit
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk_out("abort.bit2", 1'b0, 1'b1, 1'b1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_out("abort.cut", 1'b0, 1'b0, 1'b0, 1'b0);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) n_done++;
    end
    chk("abort.nodone", n_done, 32'd0);

    // full transfer after abort
    code = 5'b11010;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("post.bit%0d", i), code[4-i], 1'b1, 1'b1, 1'b0);
      tick();
    end
    tick();
    tick();
    chk_out("post.done", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // asynchronous reset mid-SEND
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_out("arst.before", 1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_out("arst.now", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("arst.busy0", {31'd0, busy0}, 32'd0);
    tick();
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk_out("arst.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
